// File: rtl/decoder_seq_pkg.sv
// Shared types and helpers for the registered one-hot decoder (decoder_seq).
// The optional wrap-around scan is selected by the DECODER_SEQ_WRAP_EN macro.
package decoder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam int unsigned ONEHOT_MAX_W = 256;

  // Returns a vector with only bit idx set; indices outside width yield zero.
  function automatic logic [ONEHOT_MAX_W-1:0] onehot_of(input int unsigned idx,
                                                        input int unsigned width);
    logic [ONEHOT_MAX_W-1:0] v;
    v = '0;
    if (idx < width && idx < ONEHOT_MAX_W) begin
      v[idx[7:0]] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/decoder_seq_onehot_dec.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder, the parametrised form of the
// old fixed 3-to-8 gate-level decoder.
module onehot_dec
  import decoder_seq_pkg::*;
#(
  parameter  int SEL_W = 3,
  localparam int OUT_W = 2**SEL_W
) (
  input  logic [SEL_W-1:0] idx,
  output logic [OUT_W-1:0] onehot
);

  assign onehot = OUT_W'(onehot_of(32'(idx), OUT_W));

endmodule

// File: rtl/decoder_seq.sv
// Registered one-hot decoder with valid/ready on both sides and a SCAN mode.
// Define DECODER_SEQ_WRAP_EN to make a SCAN cover all OUT_W indices from in_sel.
module decoder_seq
  import decoder_seq_pkg::*;
#(
  parameter  int SEL_W = 3,
  localparam int OUT_W = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_scan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_onehot,
  output logic [SEL_W-1:0] out_idx,
  output logic             out_last
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0] end_q, end_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] onehot_q, onehot_d;
  logic             ready_en_q;
  logic [OUT_W-1:0] dec_onehot;
  logic [SEL_W-1:0] cmd_end;
  logic [SEL_W-1:0] idx_inc;
  logic             accept;
  logic             out_hs;

`ifdef DECODER_SEQ_WRAP_EN
  assign cmd_end = in_sel - SEL_W'(1);
`else
  assign cmd_end = '1;
`endif

  assign idx_inc = idx_q + SEL_W'(1);

  // ready_en_q keeps the input closed until the first edge after reset release.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = ready_en_q;
      DIRECT:  in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign out_hs = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    end_d   = end_q;
    last_d  = last_q;
    valid_d = valid_q;

    case (state_q)
      IDLE, DIRECT: begin
        if (state_q == DIRECT && out_hs && !accept) begin
          state_d = IDLE;
          idx_d   = '0;
          last_d  = 1'b0;
          valid_d = 1'b0;
        end
        // DIRECT only reaches here with accept when out_hs also fires.
        if (accept) begin
          idx_d   = in_sel;
          valid_d = 1'b1;
          if (in_scan) begin
            state_d = SCAN;
            end_d   = cmd_end;
            last_d  = (in_sel == cmd_end);
          end else begin
            state_d = DIRECT;
            last_d  = 1'b1;
          end
        end
      end
      SCAN: begin
        if (out_hs) begin
          if (last_q) begin
            state_d = IDLE;
            idx_d   = '0;
            last_d  = 1'b0;
            valid_d = 1'b0;
          end else begin
            idx_d  = idx_inc;
            last_d = (idx_inc == end_q);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        last_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .idx    (idx_d),
    .onehot (dec_onehot)
  );

  assign onehot_d = valid_d ? dec_onehot : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      end_q      <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
      onehot_q   <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      end_q      <= end_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
      onehot_q   <= onehot_d;
      ready_en_q <= 1'b1;
    end
  end

  assign out_valid  = valid_q;
  assign out_onehot = onehot_q;
  assign out_idx    = idx_q;
  assign out_last   = last_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Directed, table-driven bench for decoder_seq (SEL_W = 3), with hand-written
// sequences for reset mid-scan and the DECODER_SEQ_WRAP_EN-dependent scans.
module tb_decoder_seq;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             inValid;
  logic             inReady;
  logic [SEL_W-1:0] inSel;
  logic             inScan;
  logic             outValid;
  logic             outReady;
  logic [OUT_W-1:0] outOnehot;
  logic [SEL_W-1:0] outIdx;
  logic             outLast;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       iv;
    logic [2:0] sel;
    logic       scan;
    logic       ordy;
    logic       expInReady;
    logic       expValid;
    logic [7:0] expOnehot;
    logic [2:0] expIdx;
    logic       expLast;
  } vec_t;

  vec_t vecs[$];

  decoder_seq #(.SEL_W(SEL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_sel     (inSel),
    .in_scan    (inScan),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_onehot (outOnehot),
    .out_idx    (outIdx),
    .out_last   (outLast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(logic iv, logic [2:0] sel, logic scan, logic ordy,
                                 logic eir, logic ev, logic [7:0] eoh, logic [2:0] eidx,
                                 logic el);
    vec_t v;
    v.iv = iv; v.sel = sel; v.scan = scan; v.ordy = ordy;
    v.expInReady = eir; v.expValid = ev; v.expOnehot = eoh; v.expIdx = eidx; v.expLast = el;
    return v;
  endfunction

  function automatic int scanEnd(int startSel);
`ifdef DECODER_SEQ_WRAP_EN
    return (startSel + OUT_W - 1) % OUT_W;
`else
    return OUT_W - 1;
`endif
  endfunction

  task automatic applyStimulus(input logic iv, input logic [2:0] sel, input logic scan,
                               input logic ordy);
    inValid  = iv;
    inSel    = sel;
    inScan   = scan;
    outReady = ordy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic ev, input logic [7:0] eoh,
                          input logic [2:0] eidx, input logic el);
    checkOutput({tag, " out_valid"},  32'(outValid),  32'(ev));
    checkOutput({tag, " out_onehot"}, 32'(outOnehot), 32'(eoh));
    checkOutput({tag, " out_idx"},    32'(outIdx),    32'(eidx));
    checkOutput({tag, " out_last"},   32'(outLast),   32'(el));
  endtask

  // Advance a running scan from cur to endIdx with out_ready high, then expect IDLE.
  task automatic scanTail(input int startIdx, input int endIdx, input string tag);
    int cur;
    cur = startIdx;
    for (int k = 0; k < OUT_W && cur != endIdx; k++) begin
      @(negedge clk);
      applyStimulus(1'b1, 3'd0, 1'b0, 1'b1);
      #1 checkOutput($sformatf("%s step%0d in_ready", tag, k), 32'(inReady), 32'd0);
      @(posedge clk);
      #1;
      cur = (cur + 1) % OUT_W;
      checkAll($sformatf("%s step%0d", tag, k), 1'b1, 8'(1 << cur), 3'(cur), cur == endIdx);
    end
    @(negedge clk);
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b1);
    #1 checkOutput({tag, " final in_ready"}, 32'(inReady), 32'd0);
    @(posedge clk);
    #1 checkAll({tag, " idle"}, 1'b0, 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
  endtask

  task automatic runScan(input int startSel, input string tag);
    int endIdx;
    endIdx = scanEnd(startSel);
    @(negedge clk);
    applyStimulus(1'b1, 3'(startSel), 1'b1, 1'b1);
    #1 checkOutput({tag, " accept in_ready"}, 32'(inReady), 32'd1);
    @(posedge clk);
    #1 checkAll({tag, " first"}, 1'b1, 8'(1 << startSel), 3'(startSel), startSel == endIdx);
    scanTail(startSel, endIdx, tag);
  endtask

  initial begin
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2 checkAll("reset", 1'b0, 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 checkOutput("post-reset in_ready", 32'(inReady), 32'd1);

    // iv sel scan ordy | in_ready | valid onehot idx last
    vecs.push_back(mkVec(1, 3'd5, 0, 1, 1, 1, 8'h20, 3'd5, 1));
    vecs.push_back(mkVec(0, 3'd0, 0, 1, 1, 0, 8'h00, 3'd0, 0));
    vecs.push_back(mkVec(0, 3'd0, 0, 0, 1, 0, 8'h00, 3'd0, 0));
    vecs.push_back(mkVec(1, 3'd3, 0, 0, 1, 1, 8'h08, 3'd3, 1));
    vecs.push_back(mkVec(1, 3'd0, 0, 0, 0, 1, 8'h08, 3'd3, 1));
    vecs.push_back(mkVec(1, 3'd0, 0, 0, 0, 1, 8'h08, 3'd3, 1));
    vecs.push_back(mkVec(1, 3'd0, 0, 0, 0, 1, 8'h08, 3'd3, 1));
    vecs.push_back(mkVec(1, 3'd0, 0, 0, 0, 1, 8'h08, 3'd3, 1));
    vecs.push_back(mkVec(1, 3'd0, 0, 1, 1, 1, 8'h01, 3'd0, 1));
    vecs.push_back(mkVec(0, 3'd0, 0, 1, 1, 0, 8'h00, 3'd0, 0));
    vecs.push_back(mkVec(1, 3'd0, 1, 0, 1, 1, 8'h01, 3'd0, 0));
    vecs.push_back(mkVec(0, 3'd0, 0, 1, 0, 1, 8'h02, 3'd1, 0));
    vecs.push_back(mkVec(0, 3'd0, 0, 0, 0, 1, 8'h02, 3'd1, 0));
    vecs.push_back(mkVec(0, 3'd0, 0, 1, 0, 1, 8'h04, 3'd2, 0));
    vecs.push_back(mkVec(0, 3'd0, 0, 0, 0, 1, 8'h04, 3'd2, 0));
    vecs.push_back(mkVec(0, 3'd0, 0, 1, 0, 1, 8'h08, 3'd3, 0));
    vecs.push_back(mkVec(0, 3'd0, 0, 0, 0, 1, 8'h08, 3'd3, 0));
    vecs.push_back(mkVec(0, 3'd0, 0, 1, 0, 1, 8'h10, 3'd4, 0));
    vecs.push_back(mkVec(0, 3'd0, 0, 0, 0, 1, 8'h10, 3'd4, 0));
    vecs.push_back(mkVec(0, 3'd0, 0, 1, 0, 1, 8'h20, 3'd5, 0));
    vecs.push_back(mkVec(0, 3'd0, 0, 0, 0, 1, 8'h20, 3'd5, 0));
    vecs.push_back(mkVec(0, 3'd0, 0, 1, 0, 1, 8'h40, 3'd6, 0));
    vecs.push_back(mkVec(0, 3'd0, 0, 0, 0, 1, 8'h40, 3'd6, 0));
    vecs.push_back(mkVec(0, 3'd0, 0, 1, 0, 1, 8'h80, 3'd7, 1));
    vecs.push_back(mkVec(0, 3'd0, 0, 0, 0, 1, 8'h80, 3'd7, 1));
    vecs.push_back(mkVec(0, 3'd0, 0, 1, 0, 0, 8'h00, 3'd0, 0));
    vecs.push_back(mkVec(1, 3'd2, 0, 1, 1, 1, 8'h04, 3'd2, 1));
    vecs.push_back(mkVec(1, 3'd6, 1, 1, 1, 1, 8'h40, 3'd6, 0));
    vecs.push_back(mkVec(0, 3'd0, 0, 0, 0, 1, 8'h40, 3'd6, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].iv, vecs[i].sel, vecs[i].scan, vecs[i].ordy);
      #1 checkOutput($sformatf("vec%0d in_ready", i), 32'(inReady), 32'(vecs[i].expInReady));
      @(posedge clk);
      #1 checkAll($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expOnehot,
                  vecs[i].expIdx, vecs[i].expLast);
    end

    // The table leaves a scan from 6 (entered straight from DIRECT) stalled at idx 6.
    scanTail(6, scanEnd(6), "scan6-tail");
    runScan(5, "scan5");
    runScan(7, "scan7");

    // Reset in the middle of a scan from 2 after two beats.
    @(negedge clk);
    applyStimulus(1'b1, 3'd2, 1'b1, 1'b1);
    @(posedge clk);
    #1 checkAll("rst-scan beat0", 1'b1, 8'h04, 3'd2, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1 checkAll("rst-scan beat1", 1'b1, 8'h08, 3'd3, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 checkAll("rst-scan async", 1'b0, 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 checkOutput("rst-scan in_ready", 32'(inReady), 32'd1);
    checkAll("rst-scan after", 1'b0, 8'h00, 3'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
